// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch stage: next-PC selects, FSM states and trap causes.
package pc_fetch_unit_pkg;

   localparam logic [1:0] PCSRC_SEQ  = 2'b00;
   localparam logic [1:0] PCSRC_BR   = 2'b01;
   localparam logic [1:0] PCSRC_JALR = 2'b10;

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10,
      ST_TRAP = 2'b11
   } fetch_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_RANGE    = 2'b10
   } trap_cause_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC select plus alignment and instruction-memory range checks.
module pc_fetch_unit_next_pc_calc
   import pc_fetch_unit_pkg::*;
#(
   parameter int IMEM_WORDS = 64
) (
   input  logic [31:0] pc,
   input  logic [1:0]  pc_src,
   input  logic [31:0] imm_ext,
   input  logic [31:0] jalr_target,
   output logic [31:0] next_pc,
   output logic [31:0] pc_plus4,
   output logic        misaligned,
   output logic        out_of_range
);

   assign pc_plus4 = pc + 32'd4;

   // The reserved select 11 falls through to sequential.
   always_comb begin
      next_pc = pc_plus4;
      case (pc_src)
         PCSRC_BR:   next_pc = pc + imm_ext;
         PCSRC_JALR: next_pc = jalr_target & ~32'h1;
         default:    next_pc = pc_plus4;
      endcase
   end

   assign misaligned   = (next_pc[1:0] != 2'b00);
   assign out_of_range = ({2'b00, next_pc[31:2]} >= 32'(IMEM_WORDS));

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM (boot bubble, halt, sticky trap) and saturating retire counter.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          IMEM_WORDS   = 64
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Stall,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] ImmExt,
   input  logic [31:0] JalrTarget,
   input  logic        HaltReq,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic [31:0] IMemAddr,
   output logic        Valid,
   output logic        Trap,
   output logic [1:0]  TrapCause,
   output logic [31:0] RetireCount,
   output logic [1:0]  State
);

   fetch_state_t state_q, state_d;
   trap_cause_t  cause_q, cause_d;
   logic [31:0]  pc_q, pc_d, retire_q, next_pc;
   logic         retire, misaligned, out_of_range;

   pc_fetch_unit_next_pc_calc #(.IMEM_WORDS(IMEM_WORDS)) u_next_pc_calc (
      .pc           (pc_q),
      .pc_src       (PCSrc),
      .imm_ext      (ImmExt),
      .jalr_target  (JalrTarget),
      .next_pc      (next_pc),
      .pc_plus4     (PCPlus4),
      .misaligned   (misaligned),
      .out_of_range (out_of_range)
   );

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q  <= ST_BOOT;
         cause_q  <= CAUSE_NONE;
         pc_q     <= RESET_VECTOR;
         retire_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
         if (retire && (retire_q != 32'hFFFF_FFFF))
            retire_q <= retire_q + 32'd1;
      end
   end

   // Halt outranks a bad target; a faulting instruction still retires with PC held.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      pc_d    = pc_q;
      retire  = 1'b0;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (!Stall) begin
               retire = 1'b1;
               if (HaltReq) begin
                  state_d = ST_HALT;
               end else if (misaligned) begin
                  state_d = ST_TRAP;
                  cause_d = CAUSE_MISALIGN;
               end else if (out_of_range) begin
                  state_d = ST_TRAP;
                  cause_d = CAUSE_RANGE;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         default: state_d = state_q;
      endcase
   end

   assign PC          = pc_q;
   assign IMemAddr    = {2'b00, pc_q[31:2]};
   assign Valid       = (state_q == ST_RUN);
   assign Trap        = (state_q == ST_TRAP);
   assign TrapCause   = cause_q;
   assign RetireCount = retire_q;
   assign State       = state_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-sequencing stage of the single-cycle RISC-V core. It sits directly upstream of the instruction memory and drives the memory's word-indexed address input. It holds the architectural PC, selects the next PC (sequential, branch/JAL, or JALR), and checks every target for alignment and range. A small FSM handles the post-reset bubble, halting (ECALL/EBREAK) and sticky fetch traps, and a counter tracks retired instructions.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, byte address loaded into PC on Reset; must be word-aligned.
- IMEM_WORDS, 64, instruction memory depth in words; a legal PC satisfies PC[31:2] < IMEM_WORDS.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  reset, synchronous, active-high.
- Stall  in  1  hold the current instruction; the PC does not advance and nothing retires.
- PCSrc  in  2  next-PC select: 00 = PC+4; 01 = PC+ImmExt (branch taken / JAL); 10 = JalrTarget; 11 = reserved, treated as 00.
- ImmExt  in  32  sign-extended immediate from the extend unit.
- JalrTarget  in  32  ALU result for JALR; bit 0 is cleared internally.
- HaltReq  in  1  current instruction is ECALL/EBREAK.
- PC  out  32  current byte PC.
- PCPlus4  out  32  PC+4, used for the JAL/JALR link value.
- IMemAddr  out  32  word index {2'b00, PC[31:2]}, drives the instruction memory address.
- Valid  out  1  the fetched instruction is live (high only in RUN).
- Trap  out  1  high while in TRAP.
- TrapCause  out  2  00 none, 01 misaligned target, 10 target out of range.
- RetireCount  out  32  count of retired instructions; saturating.
- State  out  2  00 BOOT, 01 RUN, 10 HALT, 11 TRAP.

## Operation
- **Reset:** PC=RESET_VECTOR, State=BOOT, Valid=0, Trap=0, TrapCause=00, RetireCount=0. Reset overrides all other inputs in every state, including mid-stall, HALT and TRAP.
- **BOOT:** lasts exactly one cycle, then goes to RUN. This bubble covers the instruction memory's synchronous clear. PC is held.
- **RUN:** evaluated each cycle in this priority order:
  1. Stall=1: hold PC, no retire, remain in RUN.
  2. HaltReq=1: retire the instruction, hold PC, go to HALT.
  3. Compute NextPC from PCSrc. All additions are 32-bit and wrap modulo 2^32. JALR target = JalrTarget & ~32'h1.
  4. If NextPC[1:0]≠00: retire, hold PC, TrapCause=01, go to TRAP.
  5. Else if NextPC[31:2] ≥ IMEM_WORDS: retire, hold PC, TrapCause=10, go to TRAP. This also covers sequential fall-off past the last word.
  6. Otherwise PC←NextPC and retire.
- **HALT / TRAP:** sticky until Reset. PC, TrapCause and RetireCount are frozen. All inputs are ignored, including Stall, PCSrc and HaltReq.
- **Retire:** RetireCount += 1, saturating at 32'hFFFF_FFFF.
- The PC is held on a trap, so the faulting instruction's address stays visible on PC.

## Timing
- PCPlus4, IMemAddr and Valid are combinational from registered state, so zero-latency fetch is available to the memory's asynchronous read.
- PC, State, TrapCause and RetireCount change only on the rising edge.
- First valid fetch is in the 2nd cycle after Reset deasserts:
  - edge 1: BOOT→RUN;
  - the instruction at RESET_VECTOR is Valid during cycle 2.
- Branch/jump redirect has 1-cycle latency: the target's PC appears after the edge on which the instruction is in RUN with Stall=0.
- Simultaneous events:
  - Stall with HaltReq: stall wins, and HALT is entered on the first unstalled cycle.
  - HaltReq with a bad target: HALT wins and no trap is raised.

## Structure
- The shared core package holds:
  - the PCSrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_JALR);
  - the state encodings;
  - the TrapCause encodings.
- One natural sub-module is next_pc_calc: a combinational block producing NextPC, the misaligned flag and the out-of-range flag. The FSM, PC register and counter stay in pc_fetch_unit.

## Test plan
- **Reset and boot:** Reset for 2 cycles, then release → PC=0x0, State=BOOT and Valid=0 for 1 cycle, then RUN, Valid=1, IMemAddr=0.
- **Sequential with stall:** 3 unstalled cycles with PCSrc=00 → PC=0x4, 0x8, 0xC and RetireCount=3. Stall=1 for 2 cycles → PC stays 0xC and RetireCount stays 3.
- **Branch and JALR:**
  - PC=0x10, PCSrc=01, ImmExt=0xFFFF_FFF8 → PC=0x08.
  - PCSrc=10, JalrTarget=0x21 → PC=0x20, IMemAddr=0x8.
- **Misaligned trap:** PC=0x20, PCSrc=10, JalrTarget=0x22 → TRAP, TrapCause=01, PC stays 0x20, RetireCount +1. Subsequent inputs are ignored; Reset returns to BOOT.
- **Range trap:**
  - PC=0xFC, PCSrc=00 with IMEM_WORDS=64 → TRAP, TrapCause=10, PC=0xFC.
  - PCSrc=01, ImmExt=0x100 from PC=0 → TrapCause=10.
- **Halt:** HaltReq=1 with Stall=1 → stays in RUN. Stall drops → HALT, PC frozen, RetireCount +1. Reset mid-HALT → PC=RESET_VECTOR, RetireCount=0.
